// File: rtl/abro_pkg.sv
// abro_pkg: shared defaults and ABRO state encoding for the conditioner and the ABRO FSM
package abro_pkg;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    typedef enum logic [1:0] {
        ABRO_IDLE   = 2'd0,
        ABRO_SEEN_A = 2'd1,
        ABRO_SEEN_B = 2'd2,
        ABRO_OUT    = 2'd3
    } abro_state_e;
endpackage

// File: rtl/abro_input_cond_if.sv
// abro_input_cond_if: raw button inputs and conditioned level/pulse outputs for both channels
interface abro_input_cond_if;
    logic a_raw;
    logic b_raw;
    logic a_level;
    logic b_level;
    logic a_pulse;
    logic b_pulse;
    modport master (output a_raw, b_raw, input a_level, b_level, a_pulse, b_pulse);
    modport slave (input a_raw, b_raw, output a_level, b_level, a_pulse, b_pulse);
endinterface

// File: rtl/abro_debounce_ch.sv
// abro_debounce_ch: one channel of synchroniser, debounce counter, level and rising-edge pulse
module abro_debounce_ch import abro_pkg::*; #(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_pulse;
    logic                   w_s;
    assign w_s     = r_sync[SYNC_STAGES-1];
    assign o_level = r_level;
    assign o_pulse = r_pulse;
    // counter saturates at CNT_MAX by accepting the new level, so it never wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_pulse <= 1'b0;
            if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= w_s;
                r_pulse <= w_s;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/abro_input_cond.sv
// abro_input_cond: two independent debounce channels producing clean A/B events for ABRO
module abro_input_cond import abro_pkg::*; #(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    abro_input_cond_if.slave  bus
);
    abro_debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_a (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (bus.a_raw),
        .o_level (bus.a_level),
        .o_pulse (bus.a_pulse)
    );
    abro_debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_b (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (bus.b_raw),
        .o_level (bus.b_level),
        .o_pulse (bus.b_pulse)
    );
endmodule
